// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack, buffers words in a
// small FIFO for decode. Optional misaligned-redirect trap: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        saved_pc_q, saved_pc_d;
  logic               saved_fault_q, saved_fault_d;
  logic               req_q, req_d;
  logic               fault_q, fault_d;

  logic [31:0]        buf_instr [FIFO_DEPTH];
  logic [31:0]        buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   count_q, count_d, count_after_pop;

  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        opc_q, opc_d;

  logic               fire, pop, push, flush;
  logic [31:0]        target;
  logic               target_bad;

  assign fire   = req_q && imem_ack;
  assign pop    = valid_q && out_ready;
  assign target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_bad = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target_bad      = 1'b0;
`endif

  // Control: a redirect outranks everything; an outstanding request is never
  // retargeted, it is drained in DROP and its data thrown away.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    saved_pc_d    = saved_pc_q;
    saved_fault_d = saved_fault_q;
    fault_d       = fault_q;
    push          = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (req_q && !imem_ack) begin
            state_d       = DROP;
            saved_pc_d    = target;
            saved_fault_d = target_bad;
          end else begin
            pc_d    = target;
            fault_d = target_bad;
            state_d = target_bad ? HALT : FETCH;
          end
        end else if (fire) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (fire) begin
            pc_d    = target;
            fault_d = target_bad;
            state_d = target_bad ? HALT : FETCH;
          end else begin
            saved_pc_d    = target;
            saved_fault_d = target_bad;
          end
        end else if (fire) begin
          pc_d    = saved_pc_q;
          fault_d = saved_fault_q;
          state_d = saved_fault_q ? HALT : FETCH;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target;
          fault_d = target_bad;
          state_d = target_bad ? HALT : FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FIFO bookkeeping and the registered head copy presented to decode.
  always_comb begin
    count_after_pop = count_q - CNT_W'(pop);
    rd_d            = rd_q;
    wr_d            = wr_q;
    count_d         = count_q;
    valid_d         = 1'b0;
    instr_d         = instr_q;
    opc_d           = opc_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = rd_q + PTR_W'(pop);
      wr_d    = wr_q + PTR_W'(push);
      count_d = count_after_pop + CNT_W'(push);
      valid_d = (count_d != '0);
      if (count_after_pop == '0) begin
        if (push) begin
          instr_d = imem_rdata;
          opc_d   = pc_q;
        end
      end else begin
        instr_d = buf_instr[rd_d];
        opc_d   = buf_pc[rd_d];
      end
    end
    req_d = (state_d == DROP) ||
            ((state_d == FETCH) && (count_d < CNT_W'(FIFO_DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      saved_pc_q    <= '0;
      saved_fault_q <= 1'b0;
      req_q         <= 1'b0;
      fault_q       <= 1'b0;
      rd_q          <= '0;
      wr_q          <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      opc_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      saved_pc_q    <= saved_pc_d;
      saved_fault_q <= saved_fault_d;
      req_q         <= req_d;
      fault_q       <= fault_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      opc_q         <= opc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_q] <= imem_rdata;
      buf_pc[wr_q]    <= pc_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign fetch_fault = fault_q;

endmodule
